// File: rtl/qpu_ifu_ibus_arbt_if.sv
// Request/response bus shared by the IFU, loader and memory sides of the
// instruction-bus arbiter. The master issues requests and accepts responses.
interface qpu_ifu_ibus_arbt_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic          req_valid;
   logic          req_ready;
   logic          req_read;
   logic [AW-1:0] req_addr;
   logic [DW-1:0] req_wdata;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [DW-1:0] rsp_rdata;

   modport master (
      output req_valid, req_read, req_addr, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata
   );

   modport slave (
      input  req_valid, req_read, req_addr, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata
   );
endinterface

// File: rtl/qpu_ifu_ibus_arbt.sv
// Shares the single instruction-memory port between the IFU fetch channel and
// the host program loader; one transaction outstanding, response routed to its owner.
module qpu_ifu_ibus_arbt #(
   parameter int AW = 32,
   parameter int DW = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  ldr_prio_i,
   input  logic                  ifu_block_i,
   output logic                  arb_busy_o,
   qpu_ifu_ibus_arbt_if.slave    ifu_bus,
   qpu_ifu_ibus_arbt_if.slave    ldr_bus,
   qpu_ifu_ibus_arbt_if.master   mem_bus
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_IFU_OUT = 2'd1,
      ST_LDR_OUT = 2'd2
   } state_e;

   state_e        state_q, state_d;
   logic          last_ifu_q, last_ifu_d;
   logic          ldr_wr_q, ldr_wr_d;

   logic          ldr_win_s;
   logic          ifu_sel_s;
   logic          ldr_sel_s;
   logic          ifu_req_ready_s;
   logic          ldr_req_ready_s;
   logic          cmd_valid_s;
   logic          cmd_read_s;
   logic [AW-1:0] cmd_addr_s;
   logic [DW-1:0] cmd_wdata_s;
   logic          mem_rsp_ready_s;
   logic          ifu_rsp_valid_s;
   logic [DW-1:0] ifu_rsp_instr_s;
   logic          ldr_rsp_valid_s;
   logic [DW-1:0] ldr_rsp_rdata_s;

   // IFU requests are always reads; its write-side fields carry nothing.
   logic          ifu_unused_s;
   assign ifu_unused_s = ^{ifu_bus.req_read, ifu_bus.req_wdata};

   // State, arbitration history and loader write flag.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= ST_IDLE;
         last_ifu_q <= 1'b1;
         ldr_wr_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         last_ifu_q <= last_ifu_d;
         ldr_wr_q   <= ldr_wr_d;
      end
   end

   // Selection, command mux, response routing and next state.
   always_comb begin
      state_d         = state_q;
      last_ifu_d      = last_ifu_q;
      ldr_wr_d        = ldr_wr_q;
      ldr_win_s       = 1'b0;
      ifu_sel_s       = 1'b0;
      ldr_sel_s       = 1'b0;
      ifu_req_ready_s = 1'b0;
      ldr_req_ready_s = 1'b0;
      cmd_valid_s     = 1'b0;
      cmd_read_s      = 1'b0;
      cmd_addr_s      = '0;
      cmd_wdata_s     = '0;
      mem_rsp_ready_s = 1'b0;
      ifu_rsp_valid_s = 1'b0;
      ifu_rsp_instr_s = '0;
      ldr_rsp_valid_s = 1'b0;
      ldr_rsp_rdata_s = '0;

      if (rst_i) begin
         // Outputs stay at their zero defaults while reset is held.
         state_d    = ST_IDLE;
         last_ifu_d = 1'b1;
         ldr_wr_d   = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               ldr_win_s = ldr_bus.req_valid & (ldr_prio_i | last_ifu_q);
               ifu_sel_s = ifu_bus.req_valid & ~ifu_block_i & ~ldr_win_s;
               ldr_sel_s = ldr_bus.req_valid & ~ifu_sel_s;

               // IFU ready deliberately ignores IFU valid to keep its req/rsp path loop-free.
               ifu_req_ready_s = ~ifu_block_i & ~ldr_win_s & mem_bus.req_ready;
               ldr_req_ready_s = ~ifu_sel_s & mem_bus.req_ready;
               cmd_valid_s     = ifu_sel_s | ldr_sel_s;

               if (ifu_sel_s) begin
                  cmd_read_s  = 1'b1;
                  cmd_addr_s  = ifu_bus.req_addr;
                  cmd_wdata_s = '0;
               end else if (ldr_sel_s) begin
                  cmd_read_s  = ldr_bus.req_read;
                  cmd_addr_s  = ldr_bus.req_addr;
                  cmd_wdata_s = ldr_bus.req_wdata;
               end else begin
                  cmd_read_s  = 1'b0;
                  cmd_addr_s  = '0;
                  cmd_wdata_s = '0;
               end

               if (cmd_valid_s && mem_bus.req_ready) begin
                  last_ifu_d = ifu_sel_s;
                  ldr_wr_d   = ldr_sel_s & ~ldr_bus.req_read;
                  state_d    = ifu_sel_s ? ST_IFU_OUT : ST_LDR_OUT;
               end else begin
                  state_d    = ST_IDLE;
               end
            end

            ST_IFU_OUT: begin
               ifu_rsp_valid_s = mem_bus.rsp_valid;
               ifu_rsp_instr_s = mem_bus.rsp_rdata;
               mem_rsp_ready_s = ifu_bus.rsp_ready;
               if (mem_bus.rsp_valid && ifu_bus.rsp_ready) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_IFU_OUT;
               end
            end

            ST_LDR_OUT: begin
               ldr_rsp_valid_s = mem_bus.rsp_valid;
               // A write ack carries no data; whatever the memory drives is masked.
               ldr_rsp_rdata_s = ldr_wr_q ? '0 : mem_bus.rsp_rdata;
               mem_rsp_ready_s = ldr_bus.rsp_ready;
               if (mem_bus.rsp_valid && ldr_bus.rsp_ready) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_LDR_OUT;
               end
            end

            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   assign ifu_bus.req_ready = ifu_req_ready_s;
   assign ifu_bus.rsp_valid = ifu_rsp_valid_s;
   assign ifu_bus.rsp_rdata = ifu_rsp_instr_s;

   assign ldr_bus.req_ready = ldr_req_ready_s;
   assign ldr_bus.rsp_valid = ldr_rsp_valid_s;
   assign ldr_bus.rsp_rdata = ldr_rsp_rdata_s;

   assign mem_bus.req_valid = cmd_valid_s;
   assign mem_bus.req_read  = cmd_read_s;
   assign mem_bus.req_addr  = cmd_addr_s;
   assign mem_bus.req_wdata = cmd_wdata_s;
   assign mem_bus.rsp_ready = mem_rsp_ready_s;

   assign arb_busy_o = ~rst_i & (state_q != ST_IDLE);

endmodule

// File: tb/tb_qpu_ifu_ibus_arbt.sv
// Directed bench for the instruction-bus arbiter: inputs change 1 time unit
// after the rising edge, outputs are compared 1 time unit after that.
module tb_qpu_ifu_ibus_arbt;
   logic clk = 1'b0;
   logic rst;
   logic ldr_prio;
   logic ifu_block;
   logic arb_busy;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   qpu_ifu_ibus_arbt_if #(.AW(32), .DW(32)) ifu_bus ();
   qpu_ifu_ibus_arbt_if #(.AW(32), .DW(32)) ldr_bus ();
   qpu_ifu_ibus_arbt_if #(.AW(32), .DW(32)) mem_bus ();

   qpu_ifu_ibus_arbt #(.AW(32), .DW(32)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .ldr_prio_i  (ldr_prio),
      .ifu_block_i (ifu_block),
      .arb_busy_o  (arb_busy),
      .ifu_bus     (ifu_bus),
      .ldr_bus     (ldr_bus),
      .mem_bus     (mem_bus)
   );

   task automatic chk_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One full transaction from IDLE: IFU fetches PC 0x100, loader reads 0x200.
   task automatic do_txn(input bit exp_ldr, input logic [31:0] rdata, input string tag);
      #1;
      chk_val({tag, " cmd_valid"}, mem_bus.req_valid, 1'b1);
      chk_val({tag, " cmd_addr"}, mem_bus.req_addr, exp_ldr ? 32'h0000_0200 : 32'h0000_0100);
      chk_val({tag, " ifu_ready"}, ifu_bus.req_ready, !exp_ldr);
      tick();
      mem_bus.rsp_valid = 1'b1;
      mem_bus.rsp_rdata = rdata;
      #1;
      chk_val({tag, " busy"}, arb_busy, 1'b1);
      chk_val({tag, " cmd_valid_out"}, mem_bus.req_valid, 1'b0);
      chk_val({tag, " ifu_ready_out"}, ifu_bus.req_ready, 1'b0);
      if (exp_ldr) begin
         chk_val({tag, " ldr_rsp_valid"}, ldr_bus.rsp_valid, 1'b1);
         chk_val({tag, " ldr_rsp_rdata"}, ldr_bus.rsp_rdata, rdata);
         chk_val({tag, " ifu_rsp_valid"}, ifu_bus.rsp_valid, 1'b0);
      end else begin
         chk_val({tag, " ifu_rsp_valid"}, ifu_bus.rsp_valid, 1'b1);
         chk_val({tag, " ifu_rsp_instr"}, ifu_bus.rsp_rdata, rdata);
         chk_val({tag, " ldr_rsp_valid"}, ldr_bus.rsp_valid, 1'b0);
      end
      tick();
      mem_bus.rsp_valid = 1'b0;
   endtask

   initial begin
      rst               = 1'b1;
      ldr_prio          = 1'b0;
      ifu_block         = 1'b0;
      ifu_bus.req_valid = 1'b1;
      ifu_bus.req_read  = 1'b1;
      ifu_bus.req_addr  = 32'h0000_0080;
      ifu_bus.req_wdata = 32'h0;
      ifu_bus.rsp_ready = 1'b1;
      ldr_bus.req_valid = 1'b0;
      ldr_bus.req_read  = 1'b1;
      ldr_bus.req_addr  = 32'h0000_0200;
      ldr_bus.req_wdata = 32'h0;
      ldr_bus.rsp_ready = 1'b1;
      mem_bus.req_ready = 1'b1;
      mem_bus.rsp_valid = 1'b1;
      mem_bus.rsp_rdata = 32'hFFFF_FFFF;

      // Outputs held at zero during reset even with live inputs.
      tick();
      tick();
      chk_val("rst cmd_valid", mem_bus.req_valid, 1'b0);
      chk_val("rst ifu_ready", ifu_bus.req_ready, 1'b0);
      chk_val("rst ldr_ready", ldr_bus.req_ready, 1'b0);
      chk_val("rst busy", arb_busy, 1'b0);
      chk_val("rst mem_rsp_ready", mem_bus.rsp_ready, 1'b0);
      chk_val("rst cmd_addr", mem_bus.req_addr, 32'h0);

      // IFU-only fetch of PC 0x80.
      rst = 1'b0;
      mem_bus.rsp_valid = 1'b0;
      #1;
      chk_val("fetch cmd_valid", mem_bus.req_valid, 1'b1);
      chk_val("fetch cmd_addr", mem_bus.req_addr, 32'h0000_0080);
      chk_val("fetch cmd_read", mem_bus.req_read, 1'b1);
      chk_val("fetch cmd_wdata", mem_bus.req_wdata, 32'h0);
      chk_val("fetch ifu_ready", ifu_bus.req_ready, 1'b1);
      tick();
      ifu_bus.req_valid = 1'b0;
      mem_bus.rsp_valid = 1'b1;
      mem_bus.rsp_rdata = 32'h1234_5678;
      #1;
      chk_val("fetch rsp_valid", ifu_bus.rsp_valid, 1'b1);
      chk_val("fetch rsp_instr", ifu_bus.rsp_rdata, 32'h1234_5678);
      chk_val("fetch ldr_rsp_valid", ldr_bus.rsp_valid, 1'b0);
      chk_val("fetch mem_rsp_ready", mem_bus.rsp_ready, 1'b1);
      chk_val("fetch busy", arb_busy, 1'b1);
      tick();
      mem_bus.rsp_valid = 1'b0;
      #1;
      chk_val("fetch rsp_valid_done", ifu_bus.rsp_valid, 1'b0);
      chk_val("fetch busy_done", arb_busy, 1'b0);

      // mem_cmd_ready low: command offered, no grant, history untouched.
      ifu_bus.req_valid = 1'b1;
      ifu_bus.req_addr  = 32'h0000_0100;
      ldr_bus.req_valid = 1'b1;
      mem_bus.req_ready = 1'b0;
      #1;
      chk_val("nordy cmd_valid", mem_bus.req_valid, 1'b1);
      chk_val("nordy cmd_addr", mem_bus.req_addr, 32'h0000_0200);
      chk_val("nordy ifu_ready", ifu_bus.req_ready, 1'b0);
      chk_val("nordy ldr_ready", ldr_bus.req_ready, 1'b0);
      tick();
      chk_val("nordy busy", arb_busy, 1'b0);
      mem_bus.req_ready = 1'b1;

      // Round-robin with both requesters continuously valid.
      do_txn(1'b1, 32'hA000_0001, "rr0");
      do_txn(1'b0, 32'hA000_0002, "rr1");
      do_txn(1'b1, 32'hA000_0003, "rr2");
      do_txn(1'b0, 32'hA000_0004, "rr3");

      // Strict loader priority starves the IFU.
      ldr_prio = 1'b1;
      for (int i = 0; i < 6; i++) begin
         do_txn(1'b1, 32'hB000_0000 + 32'(i), $sformatf("prio%0d", i));
      end

      // IFU blocked; loader write with ack data masked to zero.
      ldr_prio          = 1'b0;
      ifu_block         = 1'b1;
      ldr_bus.req_valid = 1'b0;
      #1;
      chk_val("blk ifu_ready", ifu_bus.req_ready, 1'b0);
      chk_val("blk cmd_valid", mem_bus.req_valid, 1'b0);
      tick();
      chk_val("blk busy", arb_busy, 1'b0);
      ldr_bus.req_valid = 1'b1;
      ldr_bus.req_read  = 1'b0;
      ldr_bus.req_addr  = 32'h0000_0040;
      ldr_bus.req_wdata = 32'hDEAD_BEEF;
      #1;
      chk_val("wr cmd_valid", mem_bus.req_valid, 1'b1);
      chk_val("wr cmd_read", mem_bus.req_read, 1'b0);
      chk_val("wr cmd_addr", mem_bus.req_addr, 32'h0000_0040);
      chk_val("wr cmd_wdata", mem_bus.req_wdata, 32'hDEAD_BEEF);
      chk_val("wr ifu_ready", ifu_bus.req_ready, 1'b0);
      tick();
      ldr_bus.req_valid = 1'b0;
      mem_bus.rsp_valid = 1'b1;
      mem_bus.rsp_rdata = 32'hFFFF_FFFF;
      #1;
      chk_val("wr ack_valid", ldr_bus.rsp_valid, 1'b1);
      chk_val("wr ack_rdata", ldr_bus.rsp_rdata, 32'h0);
      tick();
      mem_bus.rsp_valid = 1'b0;

      // Response backpressure on an IFU fetch.
      ifu_block         = 1'b0;
      ifu_bus.req_valid = 1'b1;
      ifu_bus.req_addr  = 32'h0000_0300;
      #1;
      chk_val("bp cmd_valid", mem_bus.req_valid, 1'b1);
      chk_val("bp cmd_addr", mem_bus.req_addr, 32'h0000_0300);
      tick();
      ifu_bus.req_valid = 1'b0;
      ifu_bus.rsp_ready = 1'b0;
      mem_bus.rsp_valid = 1'b1;
      mem_bus.rsp_rdata = 32'hA5A5_A5A5;
      ldr_bus.req_valid = 1'b1;
      ldr_bus.req_read  = 1'b1;
      ldr_bus.req_addr  = 32'h0000_0200;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk_val("bp mem_rsp_ready", mem_bus.rsp_ready, 1'b0);
         chk_val("bp busy", arb_busy, 1'b1);
         chk_val("bp cmd_valid", mem_bus.req_valid, 1'b0);
         chk_val("bp ldr_ready", ldr_bus.req_ready, 1'b0);
         chk_val("bp rsp_instr", ifu_bus.rsp_rdata, 32'hA5A5_A5A5);
         tick();
      end
      ifu_bus.rsp_ready = 1'b1;
      #1;
      chk_val("bp release", mem_bus.rsp_ready, 1'b1);
      tick();
      mem_bus.rsp_valid = 1'b0;
      #1;
      chk_val("bp idle busy", arb_busy, 1'b0);
      chk_val("bp next addr", mem_bus.req_addr, 32'h0000_0200);
      tick();
      chk_val("ldr_out busy", arb_busy, 1'b1);

      // Reset while the loader owns the bus.
      mem_bus.rsp_valid = 1'b1;
      mem_bus.rsp_rdata = 32'h0000_0011;
      rst = 1'b1;
      #1;
      chk_val("mrst ldr_rsp_valid", ldr_bus.rsp_valid, 1'b0);
      chk_val("mrst ldr_rsp_rdata", ldr_bus.rsp_rdata, 32'h0);
      chk_val("mrst mem_rsp_ready", mem_bus.rsp_ready, 1'b0);
      chk_val("mrst busy", arb_busy, 1'b0);
      tick();
      rst = 1'b0;
      mem_bus.rsp_valid = 1'b0;
      ldr_bus.req_valid = 1'b0;
      #1;
      chk_val("post rst busy", arb_busy, 1'b0);
      chk_val("post rst ldr_rsp_valid", ldr_bus.rsp_valid, 1'b0);
      ifu_bus.req_valid = 1'b1;
      ifu_bus.req_addr  = 32'h0000_0100;
      ldr_bus.req_valid = 1'b1;
      #1;
      chk_val("post rst tie to ldr", mem_bus.req_addr, 32'h0000_0200);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
